// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants and receiver state encoding.
// Used by both the transmit datapath and the receive stage.
package uart_pkg;

   localparam int CLKS_PER_BIT_DEF = 6;
   localparam int DATA_BITS_DEF    = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Resets to 1 so a low line during reset cannot look like a start bit.
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: 8N1 deserializer with ready/valid output
// and single-cycle framing / overrun error pulses.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int DATA_BITS    = DATA_BITS_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 Rx,
   input  logic                 rx_ready,
   output logic [DATA_BITS-1:0] Data_Out,
   output logic                 rx_valid,
   output logic                 framing_err,
   output logic                 overrun_err
);

   localparam int HALF_BIT = CLKS_PER_BIT / 2;
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS + 1);

   localparam logic [CW-1:0] HALF_M1  = CW'(HALF_BIT - 1);
   localparam logic [CW-1:0] BIT_M1   = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   logic rx_s;

   rx_state_e            state_q, state_d;
   logic [CW-1:0]        baud_q, baud_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 fe_q, fe_d;
   logic                 ov_q, ov_d;

   uart_rx_sync u_sync (
      .clk (clk),
      .rst (rst),
      .d   (Rx),
      .q   (rx_s)
   );

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q + CW'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = valid_q;
      fe_d    = 1'b0;
      ov_d    = 1'b0;

      if (valid_q && rx_ready) valid_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            baud_d = '0;
            if (!rx_s) state_d = START;
         end
         START: begin
            if (baud_q == HALF_M1) begin
               baud_d = '0;
               bit_d  = '0;
               state_d = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (baud_q == BIT_M1) begin
               baud_d  = '0;
               shift_d = {rx_s, shift_q} >> 1;
               if (bit_q == LAST_BIT) state_d = STOP;
               else bit_d = bit_q + BW'(1);
            end
         end
         STOP: begin
            if (baud_q == BIT_M1) begin
               baud_d = '0;
               if (rx_s) begin
                  state_d = IDLE;
                  // A byte accepted this same edge frees the holding register
                  if (!valid_q || rx_ready) begin
                     data_d  = shift_q;
                     valid_d = 1'b1;
                  end else begin
                     ov_d = 1'b1;
                  end
               end else begin
                  fe_d    = 1'b1;
                  state_d = WAIT_HIGH;
               end
            end
         end
         WAIT_HIGH: begin
            baud_d = '0;
            if (rx_s) state_d = IDLE;
         end
         default: begin
            baud_d  = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         fe_q    <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         fe_q    <= fe_d;
         ov_q    <= ov_d;
      end
   end

   assign Data_Out    = data_q;
   assign rx_valid    = valid_q;
   assign framing_err = fe_q;
   assign overrun_err = ov_q;

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Serial-to-parallel receive stage that consumes the line driven by the UART transmitter datapath. It uses the same frame format:
- idle high, one start bit (0), 8 data bits LSB first, one stop bit (1);
- same clocks-per-bit as the transmit baud counter (compare at 5 gives 6 clocks/bit).

Received bytes are presented on a ready/valid output with framing and overrun error flags.

Parameters:
CLKS_PER_BIT, 6, clock cycles per serial bit; must be >= 4
DATA_BITS, 8, data bits per frame
HALF_BIT, CLKS_PER_BIT/2 (integer divide), start-bit mid-sample offset; derived, not overridable

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
Rx  in  1  serial line, asynchronous to clk, idle high
rx_ready  in  1  consumer accepts Data_Out when high with rx_valid
Data_Out  out  DATA_BITS  received byte, held stable while rx_valid
rx_valid  out  1  Data_Out holds an unconsumed byte
framing_err  out  1  one-cycle pulse: stop bit sampled low
overrun_err  out  1  one-cycle pulse: good frame completed while rx_valid high and not being accepted

Behaviour:
- Reset (async, active-high):
  - state=IDLE; counters 0; shift reg 0.
  - Both synchronizer flops set to 1, so reset mid-frame or while Rx is low cannot fake a start.
  - Data_Out=0, rx_valid=0, framing_err=0, overrun_err=0.
- Rx passes through a 2-flop synchronizer; rx_s is the second flop's output. FSM uses only rx_s.
- Timing reference: pin low first captured at edge P. The FSM sees rx_s=0 and enters START at edge E=P+2 with baud counter=0.
- Baud counter: increments each cycle; clears on every sample edge and on entering START.
- IDLE: rx_s=0 -> START.
- START: sample at edge E+HALF_BIT.
  - rx_s=1 -> IDLE (glitch, no flags).
  - rx_s=0 -> DATA; bit counter=0.
- DATA: sample every CLKS_PER_BIT cycles; data bit i sampled at E+HALF_BIT+(i+1)*CLKS_PER_BIT.
  - Shift right, new bit into MSB, so bit 0 ends in Data_Out[0].
  - After bit DATA_BITS-1 -> STOP.
- STOP: sample at E+HALF_BIT+(DATA_BITS+1)*CLKS_PER_BIT.
  - rx_s=1 (good frame) -> IDLE.
    - If rx_valid=0, or rx_valid&rx_ready in the same cycle: load Data_Out and set rx_valid=1 at that edge. Latency for CLKS_PER_BIT=6: rx_valid rises at P+59.
    - If rx_valid=1 and rx_ready=0: discard the new byte, keep the old Data_Out, pulse overrun_err.
  - rx_s=0 -> pulse framing_err; Data_Out/rx_valid unchanged; -> WAIT_HIGH.
- WAIT_HIGH: stay until rx_s=1, then -> IDLE. A break (line held low) produces exactly one framing_err and no further frames.
- Handshake:
  - rx_valid clears at the edge where rx_valid&rx_ready, unless a new byte loads on the same edge; then rx_valid stays 1 with the new data.
  - rx_ready while rx_valid=0 has no effect.
- Back-to-back frames: the next start bit may begin right after the half stop-bit sample. IDLE detects it with no lost frame.
- Error flags are single-cycle and never asserted together.

Decomposition:
- Package uart_pkg:
  - state enum {IDLE, START, DATA, STOP, WAIT_HIGH};
  - default CLKS_PER_BIT and DATA_BITS constants, shared with the transmitter.
- One sub-module, uart_rx_sync: 2-flop synchronizer with async reset to 1.
- Baud counter, bit counter, FSM, shift register and output holding register stay in uart_receiver.

Test Plan:
- Reset, Rx idle high 100 cycles -> rx_valid=0, no flags, Data_Out=0.
- Drive frame 0xA5 (line 0,1,0,1,0,0,1,0,1,1), 6 clocks/bit, rx_ready=1 -> rx_valid=1 exactly at P+59, Data_Out=8'hA5, then cleared next edge.
- Rx low for 2 cycles then high -> START aborts to IDLE; no rx_valid, no flags. Then frame 0x3C -> Data_Out=8'h3C.
- Frame 0x55 with stop bit forced 0 and line held low 30 cycles -> single framing_err pulse, rx_valid stays 0; after release, frame 0x01 received correctly.
- rx_ready=0: frames 0x11 then 0x22 back-to-back -> Data_Out=8'h11 held, one overrun_err pulse at 0x22 stop sample. Third frame 0x33 with rx_ready=1 on its stop-sample cycle -> Data_Out=8'h33, rx_valid stays 1, no overrun.
- Assert rst mid-DATA of frame 0x7E with Rx low -> all outputs 0 immediately. Release while Rx high -> no false frame; next frame 0x81 received.
